riscv_mdu: RTL and testbench
============================

RISCV_MDU -- requirements
Module: riscv_mdu

Interface
REQ-001 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port start_i, input, 1: request strobe, sampled only in IDLE.
REQ-004 SHALL have port op_i, input, 3: RV32M funct3; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port rs1_data_i, input, 32: operand A, taken from register-file read_data1.
REQ-006 SHALL have port rs2_data_i, input, 32: operand B, taken from register-file read_data2.
REQ-007 SHALL have port rd_addr_i, input, 5: destination register index.
REQ-008 SHALL have port flush_i, input, 1: abort of the in-flight operation.
REQ-009 SHALL have port busy_o, output, 1: high whenever state is not IDLE.
REQ-010 SHALL have port valid_o, output, 1: one-cycle result strobe.
REQ-011 SHALL have port result_o, output, 32: result, valid while valid_o is high.
REQ-012 SHALL have port rd_addr_o, output, 5: latched destination index, driven to the register-file write_addr.
REQ-013 SHALL have port rf_we_o, output, 1: register-file write enable.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE.
REQ-015 IDLE with start_i=1 and flush_i=0 SHALL latch op_i, rs1_data_i, rs2_data_i and rd_addr_i, then go to CALC, or to DONE for the special cases in REQ-019 and REQ-020. Input changes after this edge SHALL have no effect.
REQ-016 CALC SHALL run exactly 32 iterations, one per cycle:
- multiply: shift-add on operand magnitudes, 64-bit accumulator;
- divide: restoring, on operand magnitudes.
After the 32nd iteration the FSM SHALL go to DONE.
REQ-017 Sign handling SHALL be:
- MUL, MULH, DIV, REM: both operands signed;
- MULHSU: rs1 signed, rs2 unsigned;
- MULHU, DIVU, REMU: both unsigned.
The product SHALL be negated when the operand signs differ. The quotient SHALL be negated when the dividend and divisor signs differ. The remainder SHALL take the sign of the dividend.
REQ-018 Result selection SHALL be: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32]; DIV and DIVU return the quotient; REM and REMU return the remainder.
REQ-019 Divisor 0 SHALL skip CALC. Results: DIV and DIVU return 0xFFFFFFFF; REM and REMU return the dividend.
REQ-020 Signed DIV or REM of 0x80000000 by 0xFFFFFFFF SHALL skip CALC. Results: DIV returns 0x80000000; REM returns 0.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE.
- valid_o=1;
- rf_we_o=1, except rf_we_o=0 when rd_addr_o=0;
- result_o and rd_addr_o driven per REQ-011 and REQ-012.
REQ-022 Latency from the start edge to valid_o high SHALL be 33 cycles in the normal case and 1 cycle for the special cases.
REQ-023 start_i in CALC or DONE SHALL be ignored, with no queuing and no effect on the result.
REQ-024 flush_i=1 in CALC or DONE SHALL force IDLE on the next edge, with valid_o=0 and rf_we_o=0 in that cycle.
REQ-025 flush_i=1 in IDLE SHALL block start_i in the same cycle (flush wins).
REQ-026 valid_o and rf_we_o SHALL be 0 in every cycle outside DONE. result_o SHALL hold its last value outside DONE.

Reset
REQ-027 rst_i=0 SHALL immediately force, regardless of clk_i:
- state to IDLE;
- busy_o, valid_o and rf_we_o to 0;
- result_o to 0x00000000 and rd_addr_o to 0;
- all internal accumulators, counters and latched operands to 0.
REQ-028 Reset asserted mid-operation SHALL abandon the operation, and no write SHALL be issued after release.
REQ-029 The first start SHALL be accepted on the first rising edge with rst_i=1.

Verification
REQ-030 MUL 7 x 0xFFFFFFFD (-3), rd=5 -> result_o=0xFFFFFFEB, valid_o and rf_we_o high exactly 33 cycles after start, rd_addr_o=5.
REQ-031 High-word products:
- MULH 0x80000000 x 0x80000000 -> 0x40000000;
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 Division:
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD;
- REM 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFF;
- DIVU 100/7 -> 14;
- REMU 100/7 -> 2.
REQ-033 Special cases, each with valid_o 1 cycle after start:
- DIV 5/0 -> 0xFFFFFFFF;
- REMU 5/0 -> 5;
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
- REM of the same operands -> 0.
REQ-034 Abort paths:
- flush_i pulse on CALC cycle 10 -> no valid_o, busy_o=0 on the following cycle;
- rst_i low on CALC cycle 20 -> all outputs 0 immediately, no write after release.
REQ-035 Write-enable and busy rules:
- MUL with rd=0 -> valid_o=1 and rf_we_o=0;
- second start_i pulse while busy_o=1 -> ignored, first result unchanged, exactly one valid_o pulse.

Source files
------------

// File: rtl/riscv_mdu.sv
// RV32M multiply/divide unit: 32-cycle shift-add multiplier and
// restoring divider sharing one 64-bit accumulator.
module riscv_mdu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_addr_o,
  output logic        rf_we_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;

  logic        accept;
  logic        a_sgn, b_sgn;
  logic        neg_a, neg_b;
  logic        neg_res;
  logic        div0, ovf, special;
  logic [31:0] mag_a, mag_b;
  logic [31:0] spec_res;

  assign accept = (state_q == IDLE) & start_i & ~flush_i;

  // Operand decode on the request inputs.
  assign a_sgn = ~(op_i[0] & op_i[1]) & ~(op_i[2] & op_i[0]);
  assign b_sgn = op_i[2] ? ~op_i[0] : ~op_i[1];
  assign neg_a = a_sgn & rs1_data_i[31];
  assign neg_b = b_sgn & rs2_data_i[31];
  assign mag_a = neg_a ? (~rs1_data_i + 32'd1) : rs1_data_i;
  assign mag_b = neg_b ? (~rs2_data_i + 32'd1) : rs2_data_i;

  // Remainder follows the dividend; everything else follows the sign product.
  assign neg_res = (op_i[2] & op_i[1]) ? neg_a : (neg_a ^ neg_b);

  assign div0 = (rs2_data_i == 32'd0);
  assign ovf  = op_i[2] & ~op_i[0]
              & (rs1_data_i == 32'h8000_0000)
              & (rs2_data_i == 32'hFFFF_FFFF);
  assign special = op_i[2] & (div0 | ovf);

  always_comb begin
    spec_res = rs1_data_i;
    unique case (1'b1)
      op_i[1] & div0:  spec_res = rs1_data_i;
      op_i[1] & ~div0: spec_res = 32'd0;
      ~op_i[1] & div0: spec_res = 32'hFFFF_FFFF;
      default:         spec_res = rs1_data_i;
    endcase
  end

  // One iteration of either algorithm on the accumulator.
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] div_nxt;
  logic [63:0] step;
  logic [63:0] prod_s;
  logic [31:0] quo, rem;
  logic [31:0] fin;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]}
             + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_nxt  = {mul_sum, acc_q[31:1]};
    div_sh   = {acc_q[63:32], acc_q[31]};
    div_diff = div_sh - {1'b0, b_q};
    if (div_diff[32]) begin
      div_nxt = {div_sh[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_nxt = {div_diff[31:0], acc_q[30:0], 1'b1};
    end
    step = op_q[2] ? div_nxt : mul_nxt;
  end

  always_comb begin
    prod_s = neg_q ? (~step + 64'd1) : step;
    quo    = neg_q ? (~step[31:0] + 32'd1) : step[31:0];
    rem    = neg_q ? (~step[63:32] + 32'd1) : step[63:32];
    case (op_q)
      3'b000:                 fin = prod_s[31:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[63:32];
      3'b100, 3'b101:         fin = quo;
      default:                fin = rem;
    endcase
  end

  always_comb begin
    op_d  = op_q;
    neg_d = neg_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    rd_d  = rd_q;
    res_d = res_q;
    if (accept) begin
      op_d  = op_i;
      neg_d = neg_res;
      b_d   = mag_b;
      acc_d = {32'd0, mag_a};
      cnt_d = 5'd0;
      rd_d  = rd_addr_i;
      if (special) begin
        res_d = spec_res;
      end
    end else if ((state_q == CALC) && !flush_i) begin
      acc_d = step;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        res_d = fin;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q  <= 3'd0;
      neg_q <= 1'b0;
      b_q   <= 32'd0;
      acc_q <= 64'd0;
      cnt_q <= 5'd0;
      rd_q  <= 5'd0;
      res_q <= 32'd0;
    end else begin
      op_q  <= op_d;
      neg_q <= neg_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      res_q <= res_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == 5'd31) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q != IDLE);
    valid_o   = (state_q == DONE) & ~flush_i;
    rf_we_o   = valid_o & (rd_q != 5'd0);
    result_o  = res_q;
    rd_addr_o = rd_q;
  end

endmodule

// File: tb/tb_riscv_mdu.sv
// Self-checking bench for riscv_mdu: directed RV32M cases, abort
// paths and random operations against an arithmetic reference.
module tb_riscv_mdu;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        rf_we_o;

  int total = 0;
  int bad   = 0;

  riscv_mdu dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .rf_we_o    (rf_we_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_spec(input logic [2:0] op,
                                   input logic [31:0] a, b);
    return op[2] && (b == 32'd0 ||
           (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_mdu(input logic [2:0] op,
                                          input logic [31:0] a, b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input int ghost, output logic [31:0] res);
    int c;
    int lat;
    logic [31:0] exp;
    exp = ref_mdu(op, a, b);
    lat = is_spec(op, a, b) ? 1 : 33;
    op_i = op;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i = rd;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    op_i = 3'($urandom);
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    rd_addr_i = 5'($urandom);
    c = 1;
    while (valid_o !== 1'b1 && c < 40) begin
      start_i = (ghost != 0 && c == ghost);
      @(posedge clk_i); #1;
      c++;
    end
    start_i = 1'b0;
    chk("latency", 32'(c), 32'(lat));
    chk("result", result_o, exp);
    chk("rd_addr", 32'(rd_addr_o), 32'(rd));
    chk("rf_we", 32'(rf_we_o), 32'(rd != 5'd0));
    chk("busy_done", 32'(busy_o), 32'd1);
    res = result_o;
    @(posedge clk_i); #1;
    chk("valid_after", 32'(valid_o), 32'd0);
    chk("busy_after", 32'(busy_o), 32'd0);
    chk("result_hold", result_o, exp);
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  op;
    logic [31:0] a, b;
    int n;
    int mode;

    rst_i = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i = 3'd0;
    rs1_data_i = 32'd0;
    rs2_data_i = 32'd0;
    rd_addr_i = 5'd0;
    #2;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_we", 32'(rf_we_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, r);
    chk("mul_7x-3", r, 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0, r);
    chk("mulh", r, 32'h4000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, r);
    chk("mulhu", r, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, r);
    chk("mulhsu", r, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, r);
    chk("div", r, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, r);
    chk("rem", r, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 5'd6, 0, r);
    chk("divu", r, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 5'd6, 0, r);
    chk("remu", r, 32'd2);
    run_op(3'd4, 32'd5, 32'd0, 5'd7, 0, r);
    chk("div_by0", r, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5, 32'd0, 5'd7, 0, r);
    chk("remu_by0", r, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, r);
    chk("div_ovf", r, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, r);
    chk("rem_ovf", r, 32'd0);
    run_op(3'd0, 32'd9, 32'd9, 5'd0, 0, r);
    chk("mul_rd0", r, 32'd81);

    run_op(3'd0, 32'd1234, 32'd5678, 5'd9, 5, r);
    chk("ghost_result", r, 32'd7006652);
    n = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      n += int'(valid_o);
    end
    chk("ghost_pulses", 32'(n), 32'd0);

    op_i = 3'd5;
    rs1_data_i = 32'd1000;
    rs2_data_i = 32'd7;
    rd_addr_i = 5'd10;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    #1;
    chk("flush_valid", 32'(valid_o), 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_busy", 32'(busy_o), 32'd0);
    n = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      n += int'(valid_o | rf_we_o);
    end
    chk("flush_no_valid", 32'(n), 32'd0);

    op_i = 3'd4;
    rs1_data_i = 32'd5;
    rs2_data_i = 32'd0;
    rd_addr_i = 5'd3;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("flush_done_valid", 32'(valid_o), 32'd0);
    chk("flush_done_we", 32'(rf_we_o), 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_done_busy", 32'(busy_o), 32'd0);

    start_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_idle_busy", 32'(busy_o), 32'd0);

    op_i = 3'd0;
    rs1_data_i = 32'd77;
    rs2_data_i = 32'd3;
    rd_addr_i = 5'd12;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_we", 32'(rf_we_o), 32'd0);
    chk("arst_result", result_o, 32'd0);
    chk("arst_rd", 32'(rd_addr_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      n += int'(valid_o | rf_we_o);
    end
    chk("arst_no_write", 32'(n), 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      mode = $urandom_range(0, 7);
      if (mode == 0) b = 32'd0;
      if (mode == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (mode == 2) b = 32'($urandom_range(1, 15));
      if (mode == 3) a = 32'($urandom_range(0, 255));
      run_op(op, a, b, 5'($urandom_range(0, 31)), 0, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
